// File: rtl/seg_pkg.sv
// Shared constants, state type and helpers for the 4-digit 7-segment scan controller.
// Segment patterns are active-low in {a,b,c,d,e,f,g} order.
package seg_pkg;

    localparam int unsigned NUM_DIGITS = 4;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_e;

    // Bit k set when digit k is a leading zero (digits k..top all zero); digit 0 never set.
    function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [4*NUM_DIGITS-1:0] digits);
        logic [NUM_DIGITS-1:0] m;
        logic                  all_zero;
        m        = '0;
        all_zero = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            all_zero = all_zero && (digits[4*k +: 4] == 4'd0);
            m[k]     = all_zero;
        end
        return m;
    endfunction

endpackage

// File: rtl/seg_decoder.sv
// Combinational BCD to active-low 7-segment decoder; codes 10..15 decode to blank.
module seg_decoder
    import seg_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit common-anode 7-segment display with
// anti-ghost blanking, tear-free snapshot, blink, leading-zero suppression and decimal point.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned DIGIT_CYCLES = 100000,
    parameter int unsigned BLANK_CYCLES = 1000,
    parameter int unsigned BLINK_FRAMES = 125
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] digits_i,
    input  logic        update_i,
    input  logic [3:0]  blink_i,
    input  logic [3:0]  dp_i,
    input  logic        lzs_i,
    output logic [3:0]  an_o,
    output logic [6:0]  seg_o,
    output logic        dp_o,
    output logic        frame_o
);

    localparam int unsigned CntW = $clog2(DIGIT_CYCLES);
    localparam int unsigned IdxW = $clog2(NUM_DIGITS);
    localparam int unsigned BfW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CntW-1:0] CntLast  = CntW'(DIGIT_CYCLES - 1);
    localparam logic [CntW-1:0] CntBlank = CntW'(BLANK_CYCLES);
    localparam logic [IdxW-1:0] IdxLast  = IdxW'(NUM_DIGITS - 1);
    localparam logic [BfW-1:0]  BfLast   = BfW'(BLINK_FRAMES - 1);

    state_e          state_q, state_d;
    logic            run_q, run_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [BfW-1:0]  bcnt_q, bcnt_d;
    logic            bph_q, bph_d;
    logic [15:0]     pending_q, pending_d;
    logic [15:0]     shown_q, shown_d;
    logic [3:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;
    logic            frame_q, frame_d;

    logic            slot_end;
    logic            frame_end;
    logic            frame_cur;
    logic [3:0]      dec_bcd;
    logic [6:0]      dec_seg;
    logic [3:0]      lz;
    logic            supp;

    // Counters and snapshot registers. cnt_q/idx_q describe the cycle currently on the pins;
    // run_q holds the position at frame start for the first edge after reset.
    always_comb begin
        run_d     = 1'b1;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        bcnt_d    = bcnt_q;
        bph_d     = bph_q;
        pending_d = pending_q;
        shown_d   = shown_q;

        slot_end  = run_q && (cnt_q == CntLast);
        frame_end = slot_end && (idx_q == IdxLast);
        frame_cur = run_q && (cnt_q == '0) && (idx_q == '0);

        if (!run_q) begin
            cnt_d = '0;
            idx_d = '0;
        end else if (slot_end) begin
            cnt_d = '0;
            idx_d = (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end

        if (frame_end) begin
            if (bcnt_q == BfLast) begin
                bcnt_d = '0;
                bph_d  = ~bph_q;
            end else begin
                bcnt_d = bcnt_q + BfW'(1);
            end
        end

        if (update_i) begin
            pending_d = digits_i;
        end
        if (frame_cur) begin
            shown_d = update_i ? digits_i : pending_q;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BLANK:   if (cnt_d >= CntBlank) state_d = DRIVE;
            DRIVE:   if (cnt_d == '0) state_d = BLANK;
            default: state_d = BLANK;
        endcase
    end

    assign dec_bcd = shown_d[{idx_d, 2'b00} +: 4];

    seg_decoder u_seg_decoder (
        .bcd_i (dec_bcd),
        .seg_o (dec_seg)
    );

    // Outputs are registered from next-state so the anodes track DRIVE with no extra cycle.
    always_comb begin
        an_d    = 4'b1111;
        seg_d   = SEG_BLANK;
        dp_d    = 1'b1;
        frame_d = (cnt_d == '0) && (idx_d == '0);
        lz      = lz_mask(shown_d);
        supp    = (lzs_i && lz[idx_d]) || (bph_d && blink_i[idx_d]);
        if ((state_d == DRIVE) && !supp) begin
            an_d[idx_d] = 1'b0;
            seg_d       = dec_seg;
            dp_d        = ~dp_i[idx_d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= BLANK;
            run_q     <= 1'b0;
            cnt_q     <= '0;
            idx_q     <= '0;
            bcnt_q    <= '0;
            bph_q     <= 1'b0;
            pending_q <= '0;
            shown_q   <= '0;
            an_q      <= 4'b1111;
            seg_q     <= SEG_BLANK;
            dp_q      <= 1'b1;
            frame_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            bcnt_q    <= bcnt_d;
            bph_q     <= bph_d;
            pending_q <= pending_d;
            shown_q   <= shown_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            frame_q   <= frame_d;
        end
    end

    assign an_o    = an_q;
    assign seg_o   = seg_q;
    assign dp_o    = dp_q;
    assign frame_o = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: directed and random stimulus against a
// frame/slot arithmetic model of the display.
module tb_seg_scan_ctrl;

    localparam int DC = 8;
    localparam int BC = 2;
    localparam int BF = 2;
    localparam int FR = 4 * DC;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] digits_i;
    logic        update_i;
    logic [3:0]  blink_i;
    logic [3:0]  dp_i;
    logic        lzs_i;
    logic [3:0]  an_o;
    logic [6:0]  seg_o;
    logic        dp_o;
    logic        frame_o;

    int checks = 0;
    int errors = 0;

    logic [15:0] n_dig;
    logic        n_upd;
    logic [3:0]  n_blink;
    logic [3:0]  n_dp;
    logic        n_lzs;

    // p = index of the next cycle to appear on the pins, counted from reset release
    int          p;
    logic [15:0] sh;
    logic [15:0] pend;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic        e_frame;

    seg_scan_ctrl #(
        .DIGIT_CYCLES (DC),
        .BLANK_CYCLES (BC),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .digits_i (digits_i),
        .update_i (update_i),
        .blink_i  (blink_i),
        .dp_i     (dp_i),
        .lzs_i    (lzs_i),
        .an_o     (an_o),
        .seg_o    (seg_o),
        .dp_o     (dp_o),
        .frame_o  (frame_o)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'd0:    return 7'b0000001;
            4'd1:    return 7'b1001111;
            4'd2:    return 7'b0010010;
            4'd3:    return 7'b0000110;
            4'd4:    return 7'b1001100;
            4'd5:    return 7'b0100100;
            4'd6:    return 7'b0100000;
            4'd7:    return 7'b0001111;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d got %0h expected %0h", tag, p, got, exp);
        end
    endtask

    task automatic apply();
        update_i = n_upd;
        digits_i = n_dig;
        blink_i  = n_blink;
        dp_i     = n_dp;
        lzs_i    = n_lzs;
    endtask

    // Consume the inputs of the current cycle, then predict the pins for the next one.
    task automatic model_step();
        int   f;
        int   k;
        int   c;
        logic supp;
        if (p >= 0 && p % FR == 0) sh = update_i ? digits_i : pend;
        if (update_i) pend = digits_i;
        p++;
        f       = p / FR;
        k       = (p / DC) % 4;
        c       = p % DC;
        e_frame = (p % FR == 0);
        e_an    = 4'b1111;
        e_seg   = 7'b1111111;
        e_dp    = 1'b1;
        if (c >= BC) begin
            supp = (lzs_i && k > 0 && (sh >> (4 * k)) == 16'h0000)
                || (((f / BF) % 2 == 1) && blink_i[k]);
            if (!supp) begin
                e_an  = ~(4'b0001 << k);
                e_seg = seg_of(sh[4*k +: 4]);
                e_dp  = ~dp_i[k];
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk("an_o", 32'(an_o), 32'(e_an));
        chk("seg_o", 32'(seg_o), 32'(e_seg));
        chk("dp_o", 32'(dp_o), 32'(e_dp));
        chk("frame_o", 32'(frame_o), 32'(e_frame));
        apply();
        model_step();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic to_pos(input int target);
        while (p % FR != target) tick();
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        p     = -1;
        sh    = 16'h0000;
        pend  = 16'h0000;
        apply();
        model_step();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_an"}, 32'(an_o), 32'h0000_000F);
        chk({tag, "_seg"}, 32'(seg_o), 32'h0000_007F);
        chk({tag, "_dp"}, 32'(dp_o), 32'h0000_0001);
        chk({tag, "_frame"}, 32'(frame_o), 32'h0000_0000);
    endtask

    function automatic logic [15:0] rand_bcd();
        logic [15:0] v;
        for (int i = 0; i < 4; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
        return v;
    endfunction

    initial begin
        rst_n   = 1'b0;
        n_dig   = 16'h0000;
        n_upd   = 1'b0;
        n_blink = 4'b0000;
        n_dp    = 4'b0000;
        n_lzs   = 1'b0;
        p       = -1;
        apply();
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");

        // First frame after release shows zeros on every digit.
        release_reset();
        run(FR);

        // Mid-frame update lands at the next frame start.
        run(10);
        n_dig = 16'h1234;
        n_upd = 1'b1;
        tick();
        n_upd = 1'b0;
        run(2 * FR);

        // Update coincident with frame start shows in that frame.
        to_pos(0);
        n_dig = rand_bcd();
        n_upd = 1'b1;
        tick();
        n_upd = 1'b0;
        run(FR);

        // Several updates in one frame: last one wins.
        run(5);
        for (int i = 0; i < 3; i++) begin
            n_dig = rand_bcd();
            n_upd = 1'b1;
            tick();
            n_upd = 1'b0;
            run(3);
        end
        run(2 * FR);

        // Leading-zero suppression on, then off.
        n_dig = 16'h0007;
        n_upd = 1'b1;
        tick();
        n_upd = 1'b0;
        n_lzs = 1'b1;
        run(2 * FR);
        n_lzs = 1'b0;
        run(FR);

        // Blink on digit 1.
        n_dig   = rand_bcd();
        n_upd   = 1'b1;
        tick();
        n_upd   = 1'b0;
        n_blink = 4'b0010;
        run(6 * FR);
        n_blink = 4'b0000;

        // Decimal point on digit 2 and an invalid BCD code.
        n_dp  = 4'b0100;
        n_dig = 16'h0C00;
        n_upd = 1'b1;
        tick();
        n_upd = 1'b0;
        run(2 * FR);
        n_dp  = 4'b0000;

        // Random soak: sporadic updates (any code, some leading zeros), random controls.
        for (int i = 0; i < 8 * FR; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                n_upd = 1'b1;
                n_dig = 16'($urandom) >> (4 * $urandom_range(0, 3));
            end else begin
                n_upd = 1'b0;
            end
            if (i % FR == 5) begin
                n_blink = 4'($urandom);
                n_dp    = 4'($urandom);
                n_lzs   = 1'($urandom);
            end
            tick();
        end

        // Asynchronous reset during a slot-2 drive cycle.
        n_upd   = 1'b0;
        n_blink = 4'b0000;
        n_lzs   = 1'b0;
        n_dig   = 16'h5678;
        n_upd   = 1'b1;
        tick();
        n_upd   = 1'b0;
        run(1);
        to_pos(2 * DC + 4);
        chk("pre_reset_an", 32'(an_o), 32'h0000_000B);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        repeat (2) @(posedge clk);
        n_dig = 16'h0000;
        n_dp  = 4'b0000;
        release_reset();
        run(FR);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for the stopwatch's 4-digit common-anode 7-segment display. It latches a 4-digit BCD snapshot from the timekeeping logic and walks the digits round-robin through one shared BCD-to-segment decoder. Each digit slot has an anti-ghosting blank interval. The block also provides per-digit blink, leading-zero suppression and a decimal point, and sits between the stopwatch counters and the board pins.

## Interface
- `DIGIT_CYCLES`, default 100000: clock cycles per digit slot (1 kHz slot rate at 100 MHz).
- `BLANK_CYCLES`, default 1000: cycles at the start of each slot with all anodes off. Must satisfy 1 ≤ `BLANK_CYCLES` < `DIGIT_CYCLES`.
- `BLINK_FRAMES`, default 125: full 4-digit frames per blink half-period.
- `clk`, input, 1: the only clock. All state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `digits_i`, input, 16: BCD digits. `[3:0]` is digit 0 (least significant), `[15:12]` is digit 3.
- `update_i`, input, 1: capture strobe for `digits_i`.
- `blink_i`, input, 4: per-digit blink enable.
- `dp_i`, input, 4: per-digit decimal point, active-high.
- `lzs_i`, input, 1: leading-zero suppression enable.
- `an_o`, output, 4: anodes, active-low. `an_o[k]` drives digit k.
- `seg_o`, output, 7: cathodes, active-low, order `{a,b,c,d,e,f,g}` with `seg_o[6]` = a and `seg_o[0]` = g.
- `dp_o`, output, 1: decimal-point cathode, active-low.
- `frame_o`, output, 1: one-cycle pulse at the start of every frame.

## Operation
- Slot counter `cnt` runs 0..`DIGIT_CYCLES`-1. Digit index `idx` runs 0..3 and advances when `cnt` wraps, with 3 wrapping to 0.
- Two states: `BLANK` while `cnt` < `BLANK_CYCLES`, then `DRIVE` for the rest of the slot, then back to `BLANK` of the next slot. There are no other states.
- `BLANK` state: `an_o` = 4'b1111, `seg_o` = 7'b1111111, `dp_o` = 1.
- `DRIVE` state: only `an_o[idx]` = 0. `seg_o` is the decode of `shown[idx]`. `dp_o` = ~`dp_i[idx]`, sampled live.
- Snapshot, two registers:
  - `pending` loads `digits_i` on any cycle with `update_i` = 1.
  - `shown` loads `pending` at each frame start (`cnt` = 0, `idx` = 0).
  - If `update_i` coincides with a frame start, `shown` loads `digits_i` directly.
  - `shown` never changes mid-frame, so there is no tearing.
- Decode:
  - BCD 0..9 use the standard active-low patterns: 0 → 7'b0000001, 1 → 7'b1001111, 8 → 7'b0000000.
  - Codes 10..15 produce 7'b1111111, which is blank.
- Leading-zero suppression:
  - When `lzs_i` = 1, digit k (k ≥ 1) is suppressed if `shown` digits k..3 are all zero.
  - A suppressed digit has its anode held off in `DRIVE`, and its `seg_o` and `dp_o` are blank.
  - Digit 0 is never suppressed.
- Blink:
  - Phase flop `bph` toggles every `BLINK_FRAMES` frame starts.
  - While `bph` = 1 and `blink_i[idx]` = 1, digit `idx` is treated as suppressed.
  - `blink_i` is sampled live.
- `frame_o` = 1 for exactly the cycle with `cnt` = 0 and `idx` = 0.

## Timing
- All outputs are registered from next-state values. `an_o[k]` is low exactly during the `DRIVE` cycles of slot k; there is no extra pipeline cycle.
- On `rst_n` low, asynchronously and immediately:
  - `an_o` = 4'b1111, `seg_o` = 7'b1111111, `dp_o` = 1, `frame_o` = 0.
  - `cnt` = 0, `idx` = 0, `bph` = 0, `pending` = 0, `shown` = 0.
- After release, the first edge is frame start: `frame_o` = 1 and digit 0 enters `BLANK`.
- Reset asserted mid-`DRIVE` blanks all outputs in the same cycle, with no glitch on the anodes.
- Frame period is 4·`DIGIT_CYCLES`. Blink full period is 2·`BLINK_FRAMES`·4·`DIGIT_CYCLES`.
- Any `update_i` pulse is reflected at the next frame start. Worst-case latency is 4·`DIGIT_CYCLES` cycles.
- Multiple updates within one frame: only the last one is shown.
- At most one anode is low in any cycle. No two anodes are ever low across adjacent cycles.

## Structure
- Package `seg_pkg`:
  - Segment pattern constants for 0..9, plus `SEG_BLANK` = 7'b1111111.
  - State enum `{BLANK, DRIVE}`.
  - Digit count constant `NUM_DIGITS` = 4.
- Sub-module `seg_decoder`: combinational 4-bit BCD in → 7-bit active-low segments out, blank for 10..15. Instantiated once, fed by a mux on `shown[idx]`.

## Test plan
Bench parameters: `DIGIT_CYCLES` = 8, `BLANK_CYCLES` = 2, `BLINK_FRAMES` = 2.
- **Reset and first frame:** hold `rst_n` low → outputs are 4'b1111 / 7'b1111111 / 1. Release → `frame_o` pulses on the first edge, and `an_o` = 4'b1110 for cycles 2..7 of that slot with `seg_o` = 7'b0000001.
- **Update at frame boundary:** `update_i` with `digits_i` = 16'h1234 mid-frame → frame unchanged. Next frame shows `seg_o` for 4, 3, 2, 1 on `an_o` = 1110, 1101, 1011, 0111. Repeat with the pulse coincident with `frame_o` → shows immediately.
- **Leading-zero suppression:** `shown` = 16'h0007, `lzs_i` = 1 → `an_o` is low only in slot 0, and slots 1–3 stay 4'b1111. With `lzs_i` = 0 → zeros are displayed.
- **Blink:** `blink_i` = 4'b0010 → digit 1 is driven in frames 0–1, dark in frames 2–3, driven in frames 4–5. Other digits are unaffected.
- **Decimal point and invalid BCD:** `dp_i` = 4'b0100 → `dp_o` = 0 only in slot-2 `DRIVE`. Digit value 4'hC → `seg_o` = 7'b1111111.
- **Async reset mid-DRIVE:** assert `rst_n` low during slot 2 `DRIVE` → `an_o` = 4'b1111 in the same cycle, and restart behaves as in the first scenario.
